// File: rtl/acl_fifo_pkg.sv
// Shared types and helpers for the ACL store-and-forward packet FIFO.
package acl_fifo_pkg;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_ACCEPT  = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_e;

    // One extra wrap bit so that a completely full buffer differs from an empty one.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/acl_fifo_ram.sv
// Simple dual-port RAM, DEPTH x (DATA_W+1), with a registered read port.
module acl_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DATA_W:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [DATA_W:0] rdata
);

    logic [DATA_W:0] mem [DEPTH];
    logic [DATA_W:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/acl_pkt_fifo.sv
// Store-and-forward packet FIFO: packets become readable only after their last beat;
// rejected or overflowing packets are discarded whole by rewinding the write pointer.
//
// state      | meaning
// WR_IDLE    | between packets, next valid beat starts a packet
// WR_ACCEPT  | storing beats of a packet in progress
// WR_DISCARD | swallowing the rest of a rejected packet
module acl_pkt_fifo
    import acl_fifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 2048,
    parameter int DROP_CNT_W = 16,
    localparam int PW        = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     i_rxd_tdata,
    input  logic                  i_rxd_tvalid,
    input  logic                  i_rx_tlast,
    input  logic                  i_fifo_invalid,
    input  logic                  i_rd_valid,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic                  o_rd_data_valid,
    output logic                  o_rd_last,
    output logic                  o_pkt_avail,
    output logic [PW-1:0]         o_pkt_cnt,
    output logic [DROP_CNT_W-1:0] o_drop_cnt,
    output logic                  o_full,
    output logic                  o_empty
);

    wr_state_e             state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         commit_q, commit_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         pkt_cnt_q, pkt_cnt_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  wr_en, commit, drop_last, pop, last_out;
    logic [DATA_W:0]       ram_rdata;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        commit_d  = commit_q;
        wr_en     = 1'b0;
        commit    = 1'b0;
        drop_last = 1'b0;
        if (i_rxd_tvalid) begin
            case (state_q)
                WR_DISCARD: begin
                    if (i_rx_tlast) begin
                        drop_last = 1'b1;
                        state_d   = WR_IDLE;
                    end
                end
                default: begin
                    if (i_fifo_invalid || full_q) begin
                        wr_ptr_d  = commit_q;
                        drop_last = i_rx_tlast;
                        state_d   = i_rx_tlast ? WR_IDLE : WR_DISCARD;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (i_rx_tlast) begin
                            commit   = 1'b1;
                            commit_d = wr_ptr_q + PW'(1);
                            state_d  = WR_IDLE;
                        end else begin
                            state_d  = WR_ACCEPT;
                        end
                    end
                end
            endcase
        end
    end

    // The last flag of a popped beat is only known once the RAM output registers,
    // so the packet count decrements on the cycle the last beat is presented.
    always_comb begin
        pop        = i_rd_valid && (rd_ptr_q != commit_q);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        rd_vld_d   = pop;
        last_out   = rd_vld_q && ram_rdata[DATA_W];
        pkt_cnt_d  = pkt_cnt_q + PW'(commit) - PW'(last_out);
        drop_cnt_d = (drop_last && (drop_cnt_q != '1)) ? drop_cnt_q + DROP_CNT_W'(1) : drop_cnt_q;
        full_d     = (wr_ptr_d - rd_ptr_d) == PW'(DEPTH);
        empty_d    = (commit_d == rd_ptr_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WR_IDLE;
            wr_ptr_q   <= '0;
            commit_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            commit_q   <= commit_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            rd_vld_q   <= rd_vld_d;
        end
    end

    acl_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q[PW-2:0]),
        .wdata ({i_rx_tlast, i_rxd_tdata}),
        .re    (pop),
        .raddr (rd_ptr_q[PW-2:0]),
        .rdata (ram_rdata)
    );

    assign o_rd_data       = rd_vld_q ? ram_rdata[DATA_W-1:0] : '0;
    assign o_rd_data_valid = rd_vld_q;
    assign o_rd_last       = last_out;
    assign o_pkt_avail     = (pkt_cnt_q != '0);
    assign o_pkt_cnt       = pkt_cnt_q;
    assign o_drop_cnt      = drop_cnt_q;
    assign o_full          = full_q;
    assign o_empty         = empty_q;

endmodule
